// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory path: the I/O window location, the
// register offsets inside that window, and the responder state encoding.
package cpu_mem_pkg;

  // Word addresses at or above IO_BASE decode to board I/O instead of BRAM.
  localparam logic [15:0] IO_BASE    = 16'hFF00;
  localparam int          IO_SW_OFS  = 0;   // read-only: board switches
  localparam int          IO_LED_OFS = 1;   // write-only: board LEDs

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } resp_state_e;

endpackage

// File: rtl/mem_io_regs.sv
// Memory-mapped I/O window for the responder.
// Decodes the latched request address against IO_BASE, provides the
// read-data mux (switches at IO_SW_OFS, zero elsewhere) and owns the LED
// register (written at IO_LED_OFS, all other I/O writes are dropped).
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   i_access      high in the responder's ACCESS cycle
//   i_we          latched request is a store
//   i_addr        latched request word address
//   i_wdata       latched store data
//   sw_in         board switches
//   o_is_io       i_addr falls inside the I/O window (unsigned compare)
//   o_rdata       I/O read data for i_addr
//   led_out       board LED register
module mem_io_regs #(
  parameter int                ADDR_W  = 16,
  parameter int                DATA_W  = 16,
  parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(cpu_mem_pkg::IO_BASE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_access,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [15:0]       sw_in,
  output logic              o_is_io,
  output logic [DATA_W-1:0] o_rdata,
  output logic [15:0]       led_out
);
  import cpu_mem_pkg::*;

  logic [ADDR_W-1:0] w_ofs;
  logic              w_sel_sw;
  logic              w_sel_led;
  logic [15:0]       r_led;

  assign o_is_io   = (i_addr >= IO_BASE);
  assign w_ofs     = i_addr - IO_BASE;
  assign w_sel_sw  = o_is_io && (w_ofs == ADDR_W'(IO_SW_OFS));
  assign w_sel_led = o_is_io && (w_ofs == ADDR_W'(IO_LED_OFS));

  // Unmapped I/O reads return zero.
  assign o_rdata = w_sel_sw ? DATA_W'(sw_in) : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_led <= '0;
    end else if (i_access && i_we && w_sel_led) begin
      r_led <= 16'(i_wdata);
    end
  end

  assign led_out = r_led;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the control FSM's fetch/load/store requests.
// One request at a time is accepted over req_valid/req_ready, served from a
// single-port BRAM with fixed read latency RAM_LAT or from the I/O window,
// and completed with a one-cycle resp_valid pulse.
// Ports:
//   clk, rst                    clock, synchronous active-low reset
//   req_valid/req_ready         request handshake (ready only when idle)
//   req_we/req_addr/req_wdata   request fields, latched on accept
//   resp_valid                  one-cycle completion pulse
//   resp_rdata                  read data, held until the next read completes
//   mem_en/mem_we/mem_addr/mem_wdata  BRAM port, driven in the ACCESS cycle
//   mem_rdata                   BRAM read data, RAM_LAT cycles after mem_en
//   sw_in                       board switches
//   led_out                     board LED register
module mem_responder #(
  parameter int                ADDR_W  = 16,
  parameter int                DATA_W  = 16,
  parameter int                RAM_LAT = 2,
  parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(cpu_mem_pkg::IO_BASE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [15:0]       sw_in,
  output logic [15:0]       led_out
);
  import cpu_mem_pkg::*;

  generate
    if (RAM_LAT < 1 || RAM_LAT > 3) begin : g_bad_lat
      $error("mem_responder: RAM_LAT must be in 1..3");
    end
  endgenerate

  resp_state_e       r_state;
  resp_state_e       w_state_nxt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [1:0]        r_cnt;
  logic [DATA_W-1:0] r_rdata;

  logic              w_accept;
  logic              w_is_io;
  logic [DATA_W-1:0] w_io_rdata;
  logic              w_cap_io;
  logic              w_cap_ram;

  assign w_accept  = req_valid && (r_state == ST_IDLE);
  assign w_cap_io  = (r_state == ST_ACCESS) && w_is_io && !r_we;
  assign w_cap_ram = (r_state == ST_WAIT) && (r_cnt == 2'd0);

  // Request latch: everything after the accept edge works from these, so the
  // initiator is free to change its request lines while we are busy.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we    <= req_we;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      // Loaded while leaving ACCESS so WAIT lasts exactly RAM_LAT cycles.
      if (r_state == ST_ACCESS) begin
        r_cnt <= 2'(RAM_LAT - 1);
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt - 2'd1;
      end
      if (w_cap_io) begin
        r_rdata <= w_io_rdata;
      end else if (w_cap_ram) begin
        r_rdata <= mem_rdata;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!w_is_io) begin
          mem_en    = 1'b1;
          mem_we    = r_we;
          mem_addr  = r_addr;
          mem_wdata = r_wdata;
        end
        w_state_nxt = (!w_is_io && !r_we) ? ST_WAIT : ST_RESP;
      end
      ST_WAIT: begin
        if (r_cnt == 2'd0) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        resp_valid  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign resp_rdata = r_rdata;

  mem_io_regs #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .IO_BASE (IO_BASE)
  ) u_io (
    .clk      (clk),
    .rst      (rst),
    .i_access (r_state == ST_ACCESS),
    .i_we     (r_we),
    .i_addr   (r_addr),
    .i_wdata  (r_wdata),
    .sw_in    (sw_in),
    .o_is_io  (w_is_io),
    .o_rdata  (w_io_rdata),
    .led_out  (led_out)
  );

endmodule
